route_lookup_arbiter: RTL
=========================

Name: route_lookup_arbiter

Overview:
- Shares one `router_searcher` instance between NUM_REQ lookup requesters, using round-robin arbitration.
- Tracks in-flight lookups with a tag pipeline, so every searcher response is returned to the requester that issued it.
- Sequences route-table reloads: blocks new lookups, drains the pipeline, drives init mode and the entry writes, then resumes lookups.
- Sits between the packet-parsing front ends and the searcher. Response data fields bypass this block; it supplies only routing (which requester) and status.

Parameters:
- NUM_REQ, 4, number of lookup requesters (2..8).
- IP_WIDTH, 32, destination IP width.
- ENTRY_WIDTH, 256, route entry width.
- ADDR_WIDTH, 6, table address width (64 entries).
- LOOKUP_LAT, 3, cycles from searcher lookup_valid to searcher resp_valid.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_dst_ip  in  NUM_REQ*IP_WIDTH  packed IPs; requester i occupies slice [i*IP_WIDTH +: IP_WIDTH].
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_found  out  1  hit flag, qualified by rsp_valid.
- cfg_wr_valid  in  1  table-write request.
- cfg_wr_ready  out  1  table-write accept.
- cfg_wr_addr  in  ADDR_WIDTH  entry address.
- cfg_wr_data  in  ENTRY_WIDTH  entry data.
- cfg_commit  in  1  pulse: end of load, return to lookups.
- cfg_loading  out  1  high in DRAIN and LOAD.
- srch_init_mode  out  1  to searcher init_mode.
- srch_init_entry_wr  out  1  to searcher.
- srch_init_entry_addr  out  ADDR_WIDTH  to searcher.
- srch_init_entry_data  out  ENTRY_WIDTH  to searcher.
- srch_lookup_valid  out  1  to searcher.
- srch_lookup_dst_ip  out  IP_WIDTH  to searcher.
- srch_resp_valid  in  1  from searcher.
- srch_resp_found  in  1  from searcher.
- tag_err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - all outputs 0;
  - state RUN;
  - round-robin pointer set so requester 0 has top priority;
  - tag pipeline empty; in-flight count 0.
- State RUN:
  - req_ready is the combinational one-hot round-robin grant over req_valid. The search starts at (last_grant+1) mod NUM_REQ.
  - On handshake, register srch_lookup_valid=1, srch_lookup_dst_ip=the granted IP and tag={1,id}. The pointer advances to the granted id.
  - At most one accept per cycle. When there is no request, srch_lookup_valid=0.
- Latency: request accepted in cycle c; lookup presented in c+1; rsp_valid in cycle c+1+LOOKUP_LAT (c+4 at default).
- Tag pipeline:
  - LOOKUP_LAT-deep shift register of {valid,id}, loaded from the srch_lookup_valid cycle.
  - Its head aligns with srch_resp_valid.
  - rsp_valid = head.valid & srch_resp_valid, decoded one-hot by head.id. rsp_found = srch_resp_found.
- In-flight count: 0..LOOKUP_LAT+1. It counts registered lookups not yet retired; simultaneous issue and retire leave it unchanged.
- Entering DRAIN: cfg_wr_valid high in RUN moves to DRAIN.
  - The arbiter may still complete the handshake it grants in that same cycle.
  - From the next cycle, req_ready=0 and cfg_loading=1.
- DRAIN to LOAD: when in-flight==0, move to LOAD. This guarantees the searcher never masks a response under init_mode.
- State LOAD:
  - srch_init_mode=1 and cfg_wr_ready=1.
  - Each cfg_wr_valid cycle registers srch_init_entry_wr=1 with addr/data, one write per cycle, no bubbles.
  - cfg_commit, which may arrive in the same cycle as a final write, leads to the transition below.
- Exiting LOAD:
  - Writes complete; srch_init_mode drops one cycle after the last srch_init_entry_wr.
  - Then back to RUN; the first grant is allowed in the cycle init_mode is low.
- cfg_commit outside LOAD is ignored. cfg_wr_valid in DRAIN waits with ready=0.
- tag_err is set, and held until reset, when either:
  - srch_resp_valid=1 while head.valid=0, or
  - head.valid=1 while srch_resp_valid=0.
  In either case the stray response is dropped.
- Reset mid-operation clears tags, count and state. Pending responses from the searcher after reset are dropped; the searcher shares the reset domain.

Decomposition:
- Shared package `route_pkg`:
  - ENTRY_WIDTH, IP_WIDTH, ADDR_WIDTH, LOOKUP_LAT;
  - state enum RUN/DRAIN/LOAD;
  - tag struct {valid, id}.
- Sub-module `rr_arbiter`: NUM_REQ-wide round-robin, with req, advance-enable, and one-hot grant outputs.

Test Plan:
- Single lookup: req_valid[2]=1, IP 0x0A000002 in cycle 0 -> srch_lookup_valid with that IP in cycle 1; rsp_valid=4'b0100 in cycle 4, rsp_found as returned.
- All four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_valid one-hot in that order, each 4 cycles after its accept.
- cfg_wr_valid raised while 3 lookups are in flight -> req_ready=0; all 3 responses delivered; srch_init_mode rises only after the last one.
- LOAD: writes to addr 0 and addr 63, then cfg_commit -> two srch_init_entry_wr pulses with matching addr/data; init_mode falls one cycle later; a subsequent lookup is granted and answered.
- Inject srch_resp_valid=1 with an empty tag pipeline -> tag_err=1, no rsp_valid, tag_err persists until rst.
- Assert rst during DRAIN with lookups in flight -> all outputs 0 that cycle; after release state is RUN and requester 0 wins first.

Source files
------------

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
// Module   : route_pkg
// Purpose  : Shared widths, FSM states and in-flight tag type for the
//            route lookup arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package route_pkg;

    localparam int IP_WIDTH    = 32;
    localparam int ENTRY_WIDTH = 256;
    localparam int ADDR_WIDTH  = 6;
    localparam int LOOKUP_LAT  = 3;
    localparam int ID_WIDTH    = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter; search starts after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter import route_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic                i_adv,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id
);

    logic [ID_WIDTH-1:0] r_last;
    logic [ID_WIDTH:0]   w_dist;
    logic [ID_WIDTH:0]   w_best;

    // Lowest rotated distance from (last+1) wins among active requesters.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_best     = '1;
        w_dist     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (ID_WIDTH+1)'(j + NUM_REQ - 1) - {1'b0, r_last};
            if (w_dist >= (ID_WIDTH+1)'(NUM_REQ))
                w_dist = w_dist - (ID_WIDTH+1)'(NUM_REQ);
            if (i_req[j] && (w_dist < w_best)) begin
                w_best     = w_dist;
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_grant_id = ID_WIDTH'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= ID_WIDTH'(NUM_REQ - 1);
        else if (i_adv && (|o_grant))
            r_last <= o_grant_id;
    end

endmodule
`default_nettype wire

// File: rtl/route_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : route_lookup_arbiter
// Purpose  : Shares one route searcher among NUM_REQ requesters, routes each
//            response back by tag, and sequences drain/reload of the table.
// Revision : 1.0 - initial release
// ============================================================================
module route_lookup_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IP_WIDTH    = route_pkg::IP_WIDTH,
    parameter int ENTRY_WIDTH = route_pkg::ENTRY_WIDTH,
    parameter int ADDR_WIDTH  = route_pkg::ADDR_WIDTH,
    parameter int LOOKUP_LAT  = route_pkg::LOOKUP_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*IP_WIDTH-1:0] req_dst_ip,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_found,
    input  logic                        cfg_wr_valid,
    output logic                        cfg_wr_ready,
    input  logic [ADDR_WIDTH-1:0]       cfg_wr_addr,
    input  logic [ENTRY_WIDTH-1:0]      cfg_wr_data,
    input  logic                        cfg_commit,
    output logic                        cfg_loading,
    output logic                        srch_init_mode,
    output logic                        srch_init_entry_wr,
    output logic [ADDR_WIDTH-1:0]       srch_init_entry_addr,
    output logic [ENTRY_WIDTH-1:0]      srch_init_entry_data,
    output logic                        srch_lookup_valid,
    output logic [IP_WIDTH-1:0]         srch_lookup_dst_ip,
    input  logic                        srch_resp_valid,
    input  logic                        srch_resp_found,
    output logic                        tag_err
);
    import route_pkg::*;

    localparam int CNT_W = $clog2(LOOKUP_LAT + 2);

    state_t                  r_state, w_next;
    logic                    r_init_mode;
    logic                    w_lookup_en, w_accept, w_fire;
    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]     w_grant_id;
    logic [IP_WIDTH-1:0]     w_grant_ip;
    logic                    r_lookup_valid;
    logic [IP_WIDTH-1:0]     r_lookup_ip;
    logic [ID_WIDTH-1:0]     r_lookup_id;
    tag_t                    r_tag [LOOKUP_LAT];
    tag_t                    w_head;
    logic [CNT_W-1:0]        r_inflight;
    logic                    r_entry_wr;
    logic [ADDR_WIDTH-1:0]   r_entry_addr;
    logic [ENTRY_WIDTH-1:0]  r_entry_data;
    logic                    r_tag_err;

    // Grants stay closed while init_mode is still high after a commit.
    assign w_lookup_en = (r_state == ST_RUN) && !r_init_mode && !rst;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req_valid & {NUM_REQ{w_lookup_en}}),
        .i_adv      (w_lookup_en),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    always_comb begin
        w_grant_ip = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (w_grant[j])
                w_grant_ip = req_dst_ip[j*IP_WIDTH +: IP_WIDTH];
    end

    always_comb begin
        w_next       = r_state;
        cfg_wr_ready = 1'b0;
        cfg_loading  = 1'b0;
        case (r_state)
            ST_RUN:   if (cfg_wr_valid) w_next = ST_DRAIN;
            ST_DRAIN: begin
                cfg_loading = 1'b1;
                if (r_inflight == '0) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                cfg_loading  = 1'b1;
                cfg_wr_ready = 1'b1;
                if (cfg_commit) w_next = ST_RUN;
            end
            default:  w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_init_mode <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_init_mode <= (w_next == ST_LOAD) || (r_state == ST_LOAD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lookup_valid <= 1'b0;
            r_lookup_ip    <= '0;
            r_lookup_id    <= '0;
        end else begin
            r_lookup_valid <= w_accept;
            if (w_accept) begin
                r_lookup_ip <= w_grant_ip;
                r_lookup_id <= w_grant_id;
            end
        end
    end

    // Head of the tag pipe lines up with the searcher response cycle.
    assign w_head = r_tag[LOOKUP_LAT-1];
    assign w_fire = w_head.valid & srch_resp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LOOKUP_LAT; k++)
                r_tag[k] <= '0;
            r_inflight <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            r_tag[0] <= {r_lookup_valid, r_lookup_id};
            for (int k = 1; k < LOOKUP_LAT; k++)
                r_tag[k] <= r_tag[k-1];
            case ({w_accept, w_head.valid})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_tag_err <= r_tag_err | (w_head.valid ^ srch_resp_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry_wr   <= 1'b0;
            r_entry_addr <= '0;
            r_entry_data <= '0;
        end else begin
            r_entry_wr <= (r_state == ST_LOAD) && cfg_wr_valid;
            if ((r_state == ST_LOAD) && cfg_wr_valid) begin
                r_entry_addr <= cfg_wr_addr;
                r_entry_data <= cfg_wr_data;
            end
        end
    end

    assign rsp_valid            = w_fire ? (NUM_REQ'(1) << w_head.id) : '0;
    assign rsp_found            = srch_resp_found & w_fire;
    assign srch_init_mode       = r_init_mode;
    assign srch_init_entry_wr   = r_entry_wr;
    assign srch_init_entry_addr = r_entry_addr;
    assign srch_init_entry_data = r_entry_data;
    assign srch_lookup_valid    = r_lookup_valid;
    assign srch_lookup_dst_ip   = r_lookup_ip;
    assign tag_err              = r_tag_err;

endmodule
`default_nettype wire
